// File: rtl/xor_stream_accum_if.sv
// ----------------------------------------------------------------------------
// xor_stream_accum_if
// Purpose : groups the operand stream (valid/ready), the mode select, the
//           combinational XOR tap and the registered result stream of
//           xor_stream_accum into one bundle.
// Signals :
//   in_valid/in_ready/in_a/in_b/in_last : operand beat stream
//   mode                                : 00 BEAT, 01 RUN, 10 FRAME, 11 as BEAT
//   out_comb                            : in_a ^ in_b, no handshake
//   out_valid/out_ready/out_data/out_last/out_par/out_count/out_sat
//                                       : registered result stream
// Modports: slave  - the accumulator block
//           master - the pattern source / result sink driving it
// ----------------------------------------------------------------------------
interface xor_stream_accum_if #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_last;
    logic [1:0]       mode;
    logic [WIDTH-1:0] out_comb;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_par;
    logic [CNT_W-1:0] out_count;
    logic             out_sat;

    modport slave (
        input  in_valid, in_a, in_b, in_last, mode, out_ready,
        output in_ready, out_comb, out_valid, out_data, out_last, out_par,
               out_count, out_sat
    );

    modport master (
        output in_valid, in_a, in_b, in_last, mode, out_ready,
        input  in_ready, out_comb, out_valid, out_data, out_last, out_par,
               out_count, out_sat
    );
endinterface

// File: rtl/xor_stream_accum.sv
// ----------------------------------------------------------------------------
// xor_stream_accum
// Purpose : streaming XOR of WIDTH-bit operand pairs with a one-entry
//           registered result stage. Three result modes: per-beat XOR (BEAT),
//           running XOR checksum within a frame (RUN), and frame-final
//           checksum only (FRAME). Each result carries parity, the saturating
//           beat count of its frame and a sticky saturation flag.
// Ports   :
//   clk    - rising-edge clock
//   resetn - synchronous reset, active low
//   bus    - xor_stream_accum_if.slave (operand stream, mode, comb XOR tap,
//            result stream); its WIDTH/CNT_W must match this module's.
// ----------------------------------------------------------------------------
module xor_stream_accum #(
    parameter int WIDTH = 8,
    parameter int CNT_W = 8
) (
    input  logic                   clk,
    input  logic                   resetn,
    xor_stream_accum_if.slave      bus
);

    localparam logic [1:0]       MODE_BEAT  = 2'b00;
    localparam logic [1:0]       MODE_RUN   = 2'b01;
    localparam logic [1:0]       MODE_FRAME = 2'b10;
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};

    // Even parity: 1 when the word has an odd number of ones.
    function automatic logic even_par(input logic [WIDTH-1:0] v);
        return ^v;
    endfunction

    // Increment that sticks at the counter's maximum value.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    // Frame state
    logic             in_frame_r;
    logic [1:0]       mode_r;
    logic [WIDTH-1:0] acc_r;
    logic [CNT_W-1:0] cnt_r;
    logic             sat_r;

    // Result register
    logic             out_valid_r;
    logic [WIDTH-1:0] out_data_r;
    logic             out_last_r;
    logic             out_par_r;
    logic [CNT_W-1:0] out_count_r;
    logic             out_sat_r;

    // Next-state datapath
    logic             in_ready_s;
    logic             accept_s;
    logic             first_s;
    logic [WIDTH-1:0] x_s;
    logic [WIDTH-1:0] acc_base_s;
    logic [WIDTH-1:0] new_acc_s;
    logic [CNT_W-1:0] cnt_s;
    logic             sat_s;
    logic [1:0]       mode_s;
    logic [WIDTH-1:0] result_s;
    logic             load_s;

    // One-entry pipe: a new beat fits when the slot is empty or drains now.
    assign in_ready_s = !out_valid_r || bus.out_ready;
    assign accept_s   = bus.in_valid && in_ready_s;
    assign first_s    = !in_frame_r;
    assign x_s        = bus.in_a ^ bus.in_b;

    // Per-beat accumulate, count and mode selection; the first beat of a frame
    // starts from a clean accumulator and uses the live mode input.
    always_comb begin
        mode_s     = mode_r;
        acc_base_s = acc_r;
        cnt_s      = sat_inc(cnt_r);
        if (first_s) begin
            mode_s     = bus.mode;
            acc_base_s = {WIDTH{1'b0}};
            cnt_s      = CNT_ONE;
        end else begin
            mode_s     = mode_r;
            acc_base_s = acc_r;
            cnt_s      = sat_inc(cnt_r);
        end
        new_acc_s = acc_base_s ^ x_s;
        sat_s     = (cnt_s == CNT_MAX) || (!first_s && sat_r);
    end

    // Result selection per mode; FRAME only produces a result on the last beat
    // and the reserved encoding behaves like BEAT.
    always_comb begin
        result_s = x_s;
        load_s   = 1'b0;
        case (mode_s)
            MODE_BEAT: begin
                result_s = x_s;
                load_s   = accept_s;
            end
            MODE_RUN: begin
                result_s = new_acc_s;
                load_s   = accept_s;
            end
            MODE_FRAME: begin
                result_s = new_acc_s;
                load_s   = accept_s && bus.in_last;
            end
            default: begin
                result_s = x_s;
                load_s   = accept_s;
            end
        endcase
    end

    // Frame tracking: the last beat returns everything to the idle values.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            in_frame_r <= 1'b0;
            mode_r     <= 2'b00;
            acc_r      <= {WIDTH{1'b0}};
            cnt_r      <= {CNT_W{1'b0}};
            sat_r      <= 1'b0;
        end else if (accept_s) begin
            mode_r <= mode_s;
            if (bus.in_last) begin
                in_frame_r <= 1'b0;
                acc_r      <= {WIDTH{1'b0}};
                cnt_r      <= {CNT_W{1'b0}};
                sat_r      <= 1'b0;
            end else begin
                in_frame_r <= 1'b1;
                acc_r      <= new_acc_s;
                cnt_r      <= cnt_s;
                sat_r      <= sat_s;
            end
        end else begin
            in_frame_r <= in_frame_r;
        end
    end

    // Result register: load wins over retire, so retire+load keeps valid high.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WIDTH{1'b0}};
            out_last_r  <= 1'b0;
            out_par_r   <= 1'b0;
            out_count_r <= {CNT_W{1'b0}};
            out_sat_r   <= 1'b0;
        end else if (load_s) begin
            out_valid_r <= 1'b1;
            out_data_r  <= result_s;
            out_last_r  <= bus.in_last;
            out_par_r   <= even_par(result_s);
            out_count_r <= cnt_s;
            out_sat_r   <= sat_s;
        end else if (bus.out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign bus.in_ready  = in_ready_s;
    assign bus.out_comb  = x_s;
    assign bus.out_valid = out_valid_r;
    assign bus.out_data  = out_data_r;
    assign bus.out_last  = out_last_r;
    assign bus.out_par   = out_par_r;
    assign bus.out_count = out_count_r;
    assign bus.out_sat   = out_sat_r;

endmodule

// File: tb/tb_xor_stream_accum.sv
// ----------------------------------------------------------------------------
// tb_xor_stream_accum
// Two instances share one stimulus stream: dut8 (CNT_W=8) and dut2 (CNT_W=2),
// so saturation is visible on dut2 while dut8 shows full counts. A frame-level
// reference model (list of beat XORs of the open frame) predicts the result
// register; directed sections pin the model with hand-computed values, then a
// randomized section exercises handshake, modes and resets.
// ----------------------------------------------------------------------------
module tb_xor_stream_accum;

    logic clk = 1'b0;
    logic resetn;

    always #5 clk = ~clk;

    xor_stream_accum_if #(.WIDTH(8), .CNT_W(8)) bus8 ();
    xor_stream_accum_if #(.WIDTH(8), .CNT_W(2)) bus2 ();

    assign bus2.in_valid  = bus8.in_valid;
    assign bus2.in_a      = bus8.in_a;
    assign bus2.in_b      = bus8.in_b;
    assign bus2.in_last   = bus8.in_last;
    assign bus2.mode      = bus8.mode;
    assign bus2.out_ready = bus8.out_ready;

    xor_stream_accum #(.WIDTH(8), .CNT_W(8)) dut8 (.clk(clk), .resetn(resetn), .bus(bus8));
    xor_stream_accum #(.WIDTH(8), .CNT_W(2)) dut2 (.clk(clk), .resetn(resetn), .bus(bus2));

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    logic [7:0] frame_q[$];
    bit         m_in_frame = 1'b0;
    logic [1:0] m_mode     = 2'd0;
    bit         m_valid    = 1'b0;
    logic [7:0] m_data     = 8'd0;
    bit         m_last     = 1'b0;
    int         m_cnt8     = 0;
    bit         m_sat8     = 1'b0;
    int         m_cnt2     = 0;
    bit         m_sat2     = 1'b0;

    always @(posedge clk) begin
        bit         rdy;
        bit         ld;
        logic [7:0] sum;
        int         sz;
        ld = 1'b0;
        if (!resetn) begin
            m_valid    = 1'b0;
            m_in_frame = 1'b0;
            frame_q.delete();
        end else begin
            rdy = !m_valid || bus8.out_ready;
            if (bus8.in_valid && rdy) begin
                if (!m_in_frame) begin
                    frame_q.delete();
                    m_mode = (bus8.mode == 2'd3) ? 2'd0 : bus8.mode;
                end
                frame_q.push_back(bus8.in_a ^ bus8.in_b);
                sum = 8'd0;
                foreach (frame_q[i]) sum = sum ^ frame_q[i];
                sz = frame_q.size();
                ld = (m_mode != 2'd2) || bus8.in_last;
                if (ld) begin
                    m_data = (m_mode == 2'd0) ? frame_q[sz-1] : sum;
                    m_last = bus8.in_last;
                    m_cnt8 = (sz > 255) ? 255 : sz;
                    m_sat8 = (sz >= 255);
                    m_cnt2 = (sz > 3) ? 3 : sz;
                    m_sat2 = (sz >= 3);
                end
                m_in_frame = !bus8.in_last;
            end
            if (ld) m_valid = 1'b1;
            else if (bus8.out_ready) m_valid = 1'b0;
        end
    end

    // Every-cycle compare against the model, away from the active edge.
    always @(negedge clk) begin
        chk("out_comb", bus8.out_comb, bus8.in_a ^ bus8.in_b);
        chk("in_ready", bus8.in_ready, !m_valid || bus8.out_ready);
        chk("in_ready2", bus2.in_ready, !m_valid || bus8.out_ready);
        chk("out_valid", bus8.out_valid, m_valid);
        chk("out_valid2", bus2.out_valid, m_valid);
        if (m_valid) begin
            chk("out_data", bus8.out_data, m_data);
            chk("out_data2", bus2.out_data, m_data);
            chk("out_last", bus8.out_last, m_last);
            chk("out_par", bus8.out_par, $countones(m_data) % 2);
            chk("out_count8", bus8.out_count, m_cnt8);
            chk("out_sat8", bus8.out_sat, m_sat8);
            chk("out_count2", bus2.out_count, m_cnt2);
            chk("out_sat2", bus2.out_sat, m_sat2);
        end
    end

    // Present one beat (called just after a posedge), wait for acceptance,
    // return 1 time unit after the accepting edge.
    task automatic beat(input logic [7:0] a, input logic [7:0] b, input logic l);
        int n;
        n = 0;
        bus8.in_a     = a;
        bus8.in_b     = b;
        bus8.in_last  = l;
        bus8.in_valid = 1'b1;
        @(negedge clk);
        while (!bus8.in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            n_chk++;
            n_err++;
            $display("FAIL accept_timeout: in_ready stuck low for %0d cycles", n);
        end
        @(posedge clk);
        #1 bus8.in_valid = 1'b0;
    endtask

    initial begin
        resetn         = 1'b0;
        bus8.in_valid  = 1'b0;
        bus8.in_a      = 8'h3C;
        bus8.in_b      = 8'h0F;
        bus8.in_last   = 1'b0;
        bus8.mode      = 2'd0;
        bus8.out_ready = 1'b1;

        // 1: reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", bus8.out_valid, 1'b0);
        chk("rst_data", bus8.out_data, 8'h00);
        chk("rst_last", bus8.out_last, 1'b0);
        chk("rst_par", bus8.out_par, 1'b0);
        chk("rst_count", bus8.out_count, 8'h00);
        chk("rst_sat", bus8.out_sat, 1'b0);
        chk("rst_ready", bus8.in_ready, 1'b1);
        chk("rst_comb", bus8.out_comb, 8'h33);
        @(posedge clk);
        #1 resetn = 1'b1;

        // 2: BEAT single-beat frames
        bus8.mode = 2'd0;
        beat(8'hA5, 8'h0F, 1'b1);
        @(negedge clk);
        chk("beat_data0", bus8.out_data, 8'hAA);
        chk("beat_par0", bus8.out_par, 1'b0);
        chk("beat_cnt0", bus8.out_count, 8'd1);
        @(posedge clk); #1;
        beat(8'hFF, 8'hFF, 1'b1);
        @(negedge clk);
        chk("beat_data1", bus8.out_data, 8'h00);
        chk("beat_cnt1", bus8.out_count, 8'd1);
        @(posedge clk); #1;

        // 3: RUN 3-beat frame, then a fresh frame restarts from 0
        bus8.mode = 2'd1;
        beat(8'h01, 8'h00, 1'b0);
        @(negedge clk);
        chk("run_d0", {bus8.out_data, bus8.out_last, bus8.out_count}, {8'h01, 1'b0, 8'd1});
        @(posedge clk); #1;
        beat(8'h02, 8'h00, 1'b0);
        @(negedge clk);
        chk("run_d1", {bus8.out_data, bus8.out_last, bus8.out_count}, {8'h03, 1'b0, 8'd2});
        @(posedge clk); #1;
        beat(8'h04, 8'h00, 1'b1);
        @(negedge clk);
        chk("run_d2", {bus8.out_data, bus8.out_last, bus8.out_count}, {8'h07, 1'b1, 8'd3});
        @(posedge clk); #1;
        beat(8'h05, 8'h00, 1'b1);
        @(negedge clk);
        chk("run_restart", {bus8.out_data, bus8.out_count}, {8'h05, 8'd1});
        @(posedge clk); #1;

        // 4: FRAME, with a mid-frame mode change that must be ignored
        bus8.mode = 2'd2;
        beat(8'h10, 8'h01, 1'b0);
        bus8.mode = 2'd0;
        @(negedge clk);
        chk("frm_silent0", bus8.out_valid, 1'b0);
        @(posedge clk); #1;
        beat(8'h20, 8'h02, 1'b0);
        @(negedge clk);
        chk("frm_silent1", bus8.out_valid, 1'b0);
        @(posedge clk); #1;
        beat(8'h40, 8'h04, 1'b0);
        @(posedge clk); #1;
        beat(8'h80, 8'h08, 1'b1);
        @(negedge clk);
        chk("frm_valid", bus8.out_valid, 1'b1);
        chk("frm_result", {bus8.out_data, bus8.out_last, bus8.out_count, bus8.out_par},
            {8'hFF, 1'b1, 8'd4, 1'b0});
        @(posedge clk); #1;
        @(negedge clk);
        chk("frm_once", bus8.out_valid, 1'b0);
        @(posedge clk); #1;

        // 5: back-pressure in BEAT mode, then drain at one beat per cycle
        bus8.mode      = 2'd0;
        bus8.out_ready = 1'b0;
        bus8.in_a = 8'h12; bus8.in_b = 8'h00; bus8.in_last = 1'b1; bus8.in_valid = 1'b1;
        @(posedge clk); #1;
        bus8.in_a = 8'h34;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_ready", bus8.in_ready, 1'b0);
            chk("bp_hold", {bus8.out_valid, bus8.out_data}, {1'b1, 8'h12});
            @(posedge clk); #1;
        end
        bus8.out_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", bus8.in_ready, 1'b1);
        @(posedge clk); #1;
        bus8.in_a = 8'h56;
        @(negedge clk);
        chk("bp_drain0", {bus8.out_valid, bus8.out_data}, {1'b1, 8'h34});
        @(posedge clk); #1;
        bus8.in_valid = 1'b0;
        @(negedge clk);
        chk("bp_drain1", {bus8.out_valid, bus8.out_data}, {1'b1, 8'h56});
        @(posedge clk); #1;

        // 6: saturation on dut2 with a 5-beat RUN frame
        bus8.mode = 2'd1;
        for (int i = 0; i < 5; i++) begin
            beat(8'h01, 8'h00, (i == 4));
            @(negedge clk);
            chk("sat_cnt2", bus2.out_count, (i < 2) ? i + 1 : 3);
            chk("sat_flag2", bus2.out_sat, (i >= 2));
            chk("sat_cnt8", bus8.out_count, i + 1);
            @(posedge clk); #1;
        end

        // 6b: reset in the middle of a frame drops it and any pending result
        beat(8'h01, 8'h00, 1'b0);
        @(posedge clk); #1;
        beat(8'h02, 8'h00, 1'b0);
        @(posedge clk); #1;
        beat(8'h04, 8'h00, 1'b0);
        resetn = 1'b0;
        @(posedge clk); #1;
        resetn = 1'b1;
        @(negedge clk);
        chk("rst_mid_valid", bus8.out_valid, 1'b0);
        @(posedge clk); #1;
        beat(8'h0F, 8'h00, 1'b0);
        @(negedge clk);
        chk("rst_mid_restart", {bus8.out_data, bus8.out_count}, {8'h0F, 8'd1});
        @(posedge clk); #1;

        // Randomized traffic: handshake, all modes incl. reserved, resets
        for (int c = 0; c < 3000; c++) begin
            resetn         = ($urandom_range(0, 199) != 0);
            bus8.in_valid  = ($urandom_range(0, 3) != 0);
            bus8.out_ready = ($urandom_range(0, 3) != 0);
            bus8.in_a      = 8'($urandom);
            bus8.in_b      = 8'($urandom);
            bus8.in_last   = ($urandom_range(0, 4) == 0);
            bus8.mode      = 2'($urandom);
            @(posedge clk); #1;
        end
        bus8.in_valid  = 1'b0;
        bus8.out_ready = 1'b1;
        resetn         = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
